reaction_round_ctrl: RTL and testbench

Round sequencer for the reaction-timer game.
- Samples and debounces the raw Start button.
- Draws a random delay from the LFSR and counts it down in milliseconds.
- Drives the LED bar and sequences the external BCD score counter (clear/enable).
- Keeps the best (lowest) score.
- Sits between the board I/O, the LFSR, the BCD counter and the 7-segment display mux.

---
 rtl/reaction_round_ctrl.sv | 113 +++++++++++
 tb/tb_reaction_round_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: reaction-timer round sequencer (debounced start, random delay, score/best tracking).
// Optional false-start detection with FOUL blink state is compiled in when REACTION_FOUL_DETECT_EN is defined.
module reaction_round_ctrl #(
    parameter int DLY_W         = 11,
    parameter int MIN_DELAY_MS  = 1000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int FOUL_BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        ms_tick,
    input  logic        btn_n,
    input  logic [15:0] lfsr_val,
    input  logic [11:0] score,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic [9:0]  LED,
    output logic        done,
    output logic [11:0] best,
    output logic        new_best,
    output logic [2:0]  state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WAIT   = 3'd2,
        REACT  = 3'd3,
        RESULT = 3'd4,
        FOUL   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2, prev;
    logic [15:0] deb_cnt, dly_cnt;
    logic        timeout, timeout_nxt, timeout_hit;
    logic        press_evt, best_upd;
    logic [9:0]  led_nxt;
    logic        unused_lfsr;

    assign unused_lfsr = ^lfsr_val;
    assign state_dbg   = state;
    assign press_evt   = prev && !sync2 && deb_cnt == 16'd0;
    // a same-cycle press beats the timeout
    assign timeout_hit = state == REACT && ms_tick && score == 12'h999 && !press_evt;

`ifdef REACTION_FOUL_DETECT_EN
    logic [15:0] blink_cnt;
    logic        blink_wrap;
    assign blink_wrap = ms_tick && blink_cnt == 16'(FOUL_BLINK_MS - 1);
    always_ff @(posedge clk or negedge Reset)
        if (!Reset)
            blink_cnt <= '0;
        else
            blink_cnt <= state != FOUL ? 16'd0 : !ms_tick ? blink_cnt : blink_wrap ? 16'd0 : blink_cnt + 16'd1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = press_evt ? LOAD : IDLE;
            LOAD:    state_nxt = WAIT;
`ifdef REACTION_FOUL_DETECT_EN
            WAIT:    state_nxt = press_evt ? FOUL : dly_cnt == 16'd0 ? REACT : WAIT;
            FOUL:    state_nxt = press_evt ? IDLE : FOUL;
`else
            WAIT:    state_nxt = dly_cnt == 16'd0 ? REACT : WAIT;
`endif
            REACT:   state_nxt = (press_evt || timeout_hit) ? RESULT : REACT;
            RESULT:  state_nxt = press_evt ? IDLE : RESULT;
            default: state_nxt = IDLE;
        endcase
        timeout_nxt = state_nxt == IDLE ? 1'b0 : (timeout || timeout_hit);
        best_upd    = state == REACT && state_nxt == RESULT && !timeout_nxt && score < best;
        led_nxt     = state_nxt == REACT ? 10'h3FF : 10'h000;
`ifdef REACTION_FOUL_DETECT_EN
        if (state_nxt == FOUL)
            led_nxt = state != FOUL ? 10'h2AA : blink_wrap ? ~LED : LED;
`endif
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            prev     <= 1'b1;
            deb_cnt  <= '0;
            dly_cnt  <= '0;
            state    <= IDLE;
            timeout  <= 1'b0;
            LED      <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            done     <= 1'b0;
            best     <= 12'h999;
            new_best <= 1'b0;
        end else begin
            sync1    <= btn_n;
            sync2    <= sync1;
            prev     <= sync2;
            deb_cnt  <= press_evt ? 16'(DEBOUNCE_MS) : (ms_tick && deb_cnt != 16'd0) ? deb_cnt - 16'd1 : deb_cnt;
            dly_cnt  <= state == LOAD ? 16'(MIN_DELAY_MS) + 16'(lfsr_val[DLY_W-1:0]) :
                        (state == WAIT && ms_tick && dly_cnt != 16'd0) ? dly_cnt - 16'd1 : dly_cnt;
            state    <= state_nxt;
            timeout  <= timeout_nxt;
            LED      <= led_nxt;
            cnt_en   <= state_nxt == REACT;
            cnt_clr  <= state_nxt == LOAD;
            done     <= state_nxt == RESULT || state_nxt == FOUL;
            best     <= best_upd ? score : best;
            new_best <= best_upd;
        end
    end
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb_reaction_round_ctrl: randomized rounds checked against a round-level model of the game rules.
module tb_reaction_round_ctrl;
    logic        clk = 1'b0;
    logic        Reset, ms_tick, btn_n;
    logic [15:0] lfsr_val;
    logic [11:0] score;
    logic        cnt_clr, cnt_en, done, new_best;
    logic [9:0]  LED;
    logic [11:0] best;
    logic [2:0]  state_dbg;

    int checks = 0, errors = 0;
    int wait_ticks = 0, foul_ticks = 0;
    int t0, t0f, exp_ticks;
    logic [11:0] best_m;
    bit to_round, foul_r, exp_nb;

    reaction_round_ctrl #(.DLY_W(11), .MIN_DELAY_MS(4), .DEBOUNCE_MS(2), .FOUL_BLINK_MS(3)) dut (
        .clk(clk), .Reset(Reset), .ms_tick(ms_tick), .btn_n(btn_n), .lfsr_val(lfsr_val),
        .score(score), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .LED(LED), .done(done),
        .best(best), .new_best(new_best), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ms_tick && state_dbg == 3'd2) wait_ticks <= wait_ticks + 1;
        if (ms_tick && state_dbg == 3'd5) foul_ticks <= foul_ticks + 1;
    end

    initial begin
        ms_tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            ms_tick = 1'b1;
            @(negedge clk);
            ms_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        @(negedge clk) btn_n = 1'b0;
        cyc(3);
    endtask

    task automatic release_btn();
        @(negedge clk) btn_n = 1'b1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
        for (int i = 0; i < lim && state_dbg !== s; i++) cyc(1);
        check(tag, 32'(state_dbg), 32'(s));
    endtask

    function automatic logic [11:0] rand_bcd();
        return {4'($urandom_range(0, 8)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        Reset = 1'b0; btn_n = 1'b1; score = '0; lfsr_val = 16'h0003; best_m = 12'h999;
        #23;
        check("rst_state", 32'(state_dbg), 0);
        check("rst_led", 32'(LED), 0);
        check("rst_best", 32'(best), 32'h999);
        check("rst_done", 32'(done), 0);
        check("rst_cnt_en", 32'(cnt_en), 0);
        check("rst_cnt_clr", 32'(cnt_clr), 0);
        @(negedge clk) Reset = 1'b1;
        cyc(30);
        for (int r = 0; r < 10; r++) begin
            score    = r == 0 ? 12'h245 : r == 1 ? 12'h300 : r == 2 ? best_m : rand_bcd();
            to_round = r == 3 || (r > 5 && $urandom_range(0, 3) == 0);
            foul_r   = r % 3 == 1;
            lfsr_val = r == 0 ? 16'h0003 : {5'($urandom), 11'($urandom_range(0, 4))};
            exp_ticks = 4 + int'(lfsr_val[10:0]);
            cyc($urandom_range(30, 50));
            press();
            check("load_state", 32'(state_dbg), 1);
            check("load_cnt_clr", 32'(cnt_clr), 1);
            t0 = wait_ticks;
            release_btn();
            cyc(1);
            check("wait_state", 32'(state_dbg), 2);
            check("clr_pulse", 32'(cnt_clr), 0);
            if (foul_r) begin
                cyc(22);
                press();
                release_btn();
`ifdef REACTION_FOUL_DETECT_EN
                check("foul_state", 32'(state_dbg), 5);
                check("foul_led0", 32'(LED), 32'h2AA);
                check("foul_done", 32'(done), 1);
                t0f = foul_ticks;
                for (int i = 0; i < 80 && LED !== 10'h155; i++) cyc(1);
                check("foul_blink1", 32'(foul_ticks - t0f), 3);
                for (int i = 0; i < 80 && LED !== 10'h2AA; i++) cyc(1);
                check("foul_blink2", 32'(foul_ticks - t0f), 6);
                press();
                check("foul_exit", 32'(state_dbg), 0);
                check("foul_exit_led", 32'(LED), 0);
                check("foul_best", 32'(best), 32'(best_m));
                release_btn();
                continue;
`else
                check("wait_press_ignored", 32'(state_dbg), 2);
`endif
            end
            wait_state("react_state", 3, 200);
            check("wait_ticks", 32'(wait_ticks - t0), 32'(exp_ticks));
            check("react_led", 32'(LED), 32'h3FF);
            check("react_cnt_en", 32'(cnt_en), 1);
            if (to_round) begin
                score = 12'h999;
                wait_state("timeout_state", 4, 30);
                check("to_new_best", 32'(new_best), 0);
                check("to_done", 32'(done), 1);
                check("to_cnt_en", 32'(cnt_en), 0);
                check("to_best", 32'(best), 32'(best_m));
                cyc(5);
            end else begin
                cyc(30);
                exp_nb = score < best_m;
                if (exp_nb) best_m = score;
                press();
                check("res_state", 32'(state_dbg), 4);
                check("res_done", 32'(done), 1);
                check("res_cnt_en", 32'(cnt_en), 0);
                check("res_led", 32'(LED), 0);
                check("res_best", 32'(best), 32'(best_m));
                check("res_new_best", 32'(new_best), 32'(exp_nb));
                if (r == 5) begin
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk) btn_n = 1'b1;
                        @(negedge clk) btn_n = 1'b0;
                    end
                    cyc(4);
                    check("bounce_hold", 32'(state_dbg), 4);
                end
                release_btn();
                cyc(1);
                check("new_best_pulse", 32'(new_best), 0);
                cyc(30);
            end
            press();
            check("idle_state", 32'(state_dbg), 0);
            check("idle_done", 32'(done), 0);
            release_btn();
        end
        score = 12'h000;
        cyc(40);
        press();
        release_btn();
        wait_state("final_react", 3, 200);
        #3 Reset = 1'b0;
        #1;
        check("async_state", 32'(state_dbg), 0);
        check("async_led", 32'(LED), 0);
        check("async_cnt_en", 32'(cnt_en), 0);
        check("async_done", 32'(done), 0);
        check("async_best", 32'(best), 32'h999);
        check("async_new_best", 32'(new_best), 0);
        @(negedge clk) Reset = 1'b1;
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
